alu_sequencer: RTL and testbench
================================

# alu_sequencer

Controller that sequences one `ALU_cells` datapath through a complete neuron evaluation: up to nine element-wise products, their summation, and a bias add.
- Products are formed from memory bank 1 × memory bank 2 and written back into bank 2.
- The summed result plus the selected bias is steered to a chosen destination through the datapath's output demux.
- The block sits between the autoencoder top-level control FSM (start/done handshake) and the `ALU_cells` mux, op and demux control inputs.

## Interface
Parameters:
- `N_MAX`, 9 — maximum number of terms per command; equals the number of words per memory bank.

Ports (all outputs are registered):
- `clk`  in  1  — single system clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — command strobe; sampled only in IDLE.
- `cmd_len`  in  4  — number of terms, legal range 1..9.
- `cmd_bias_sel`  in  1  — 0 selects `input_bias`, 1 selects `output_bias`.
- `cmd_dest`  in  4  — demux code for the final result.
- `busy`  out  1  — high from the cycle after an accepted `start` through the DONE cycle.
- `done`  out  1  — one-cycle pulse when the result is on the selected demux output.
- `err`  out  1  — one-cycle pulse on a rejected command.
- `mux_1_control`  out  5  — operand A select.
- `mux_2_control`  out  5  — operand B select, bank side.
- `mux_3_control`  out  2  — 0 = `input_pixel`, 1 = mux_1 path.
- `mux_4_control`  out  4  — operand B source select.
- `enable_ALU`  out  1  — ALU enable.
- `op_select`  out  2  — ALU operation.
- `demux_1_control`  out  4  — result destination.
- `mem_wr_en`  out  1  — scratch write enable for `to_memory`.
- `mem_wr_addr`  out  5  — scratch write address, same encoding as `mux_1_control`.

## Operation
Encodings:
- `op_select`: 00 ADD, 01 SUB, 10 MUL, 11 reserved (never driven).
- `mux_1_control` / `mux_2_control`: 0..8 select bank 1 word 0..8; 9..17 select bank 2 word 0..8.
- `mux_4_control`: 1 = `input_bias`, 2 = `output_bias`, 7 = mux_2 path.
- `demux_1_control`: 0 = `to_sigmoid` … 7 = `to_middle_layer_error`; 15 = no destination (idle value).

States:
- **IDLE**
  - On `start`, `cmd_len`, `cmd_bias_sel` and `cmd_dest` are latched.
  - Legal `cmd_len` → MUL with i = 0.
  - `cmd_len` of 0 or > 9 → `err` pulses next cycle; state stays IDLE and no ALU activity occurs.
  - `cmd_dest` values 8..14 are treated as 15 (no destination).
- **MUL(i)**, i = 0..len-1
  - `mux_1_control` = i, `mux_3_control` = 1, `mux_2_control` = 9+i, `mux_4_control` = 7, op MUL, enable 1.
  - `mem_wr_en` = 1, `mem_wr_addr` = 9+i.
  - After i = len-1: go to ACC(1) if len > 1, otherwise BIAS.
- **ACC(k)**, k = 1..len-1
  - `mux_1_control` = 9 (running sum), `mux_2_control` = 9+k, `mux_4_control` = 7, op ADD.
  - Write back to address 9.
- **BIAS**
  - `mux_1_control` = 9, `mux_4_control` = 1 or 2 per `cmd_bias_sel`, op ADD.
  - `demux_1_control` = latched dest, `mem_wr_en` = 0.
- **DONE**
  - `done` = 1, `busy` = 1, all controls return to idle values.
  - Next state is IDLE.

Other rules:
- Arithmetic and width behaviour belong to the ALU; the sequencer only orders operations.
- Idle control values: all mux controls 0, `enable_ALU` 0, op 00, demux 15, `mem_wr_en` 0.
- `start` while `busy` is ignored; it is neither queued nor flagged as an error.

## Timing
- Reset value of every output:
  - `busy`, `done`, `err` = 0.
  - Mux controls, op and `mem_wr_addr` = 0.
  - `enable_ALU` = 0, `mem_wr_en` = 0.
  - `demux_1_control` = 15.
- Controls are Moore outputs registered on the state; MUL(0) controls appear the cycle after the `start` edge.
- Bank memory is write-at-edge with combinational read, so ACC(k) sees the value written by the previous cycle.
- Latency from the `start` edge to the `done` cycle is 2·len+1 cycles (len = 9 → 19; len = 1 → 3).
- `err` follows the rejecting `start` edge by 1 cycle.
- Asserting `rst` mid-command forces outputs to reset values immediately and abandons the command; partially written bank 2 contents are undefined.

## Structure
- Shared package `ae_ctrl_pkg` holds:
  - op codes (OP_ADD, OP_SUB, OP_MUL);
  - mux_4 and demux destination constants (DEST_NONE = 15);
  - bank base constant BANK2_BASE = 9;
  - the state enum.
- One natural sub-module, `alu_ctrl_decode`: combinational decode from (state, index, latched command) to the next control word, registered in `alu_sequencer`.
- Index counter (4 bits) and FSM live in `alu_sequencer`.

## Test plan
- Reset mid-MUL(4) → all outputs at reset values in the same cycle; `start` accepted normally after `rst` drops.
- Bank1 = 1..9, bank2 = 1..9, `input_bias` = 10, len 9, bias_sel 0, dest 0:
  - `done` 19 cycles after `start`;
  - `to_sigmoid` = 295 (285 + 10) during BIAS;
  - exactly 17 write strobes.
- len 1, bank1[0] = 3, bank2[0] = 4, `output_bias` = 5, dest 3 → `done` at cycle 3; `to_output_bias` port carries 17; no ACC state visited.
- `cmd_len` = 0, then `cmd_len` = 12 → `err` pulses 1 cycle later each time; `busy` stays 0; `enable_ALU` never asserted.
- `start` re-pulsed during ACC(3) → ignored; `done` timing and result unchanged.

Source files
------------

// File: rtl/ae_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ae_ctrl_pkg
//  Description : Shared encodings for the autoencoder ALU control path:
//                ALU op codes, mux/demux select values, bank addressing,
//                sequencer state enum and the packed ALU control word.
//  Revision    : 1.0 - initial release
// ============================================================================
package ae_ctrl_pkg;

    // ALU operation codes; 2'b11 is reserved and never driven
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    // Bank addressing shared by mux_1, mux_2 and the scratch write address:
    // 0..8 address bank 1, 9..17 address bank 2
    localparam logic [4:0] BANK2_BASE = 5'd9;

    // mux_3: operand A source
    localparam logic [1:0] MUX3_PIXEL = 2'd0;
    localparam logic [1:0] MUX3_MUX1  = 2'd1;

    // mux_4: operand B source
    localparam logic [3:0] MUX4_IDLE        = 4'd0;
    localparam logic [3:0] MUX4_INPUT_BIAS  = 4'd1;
    localparam logic [3:0] MUX4_OUTPUT_BIAS = 4'd2;
    localparam logic [3:0] MUX4_MUX2        = 4'd7;

    // demux_1 destinations; codes above DEST_LAST_VALID route nowhere
    localparam logic [3:0] DEST_TO_SIGMOID            = 4'd0;
    localparam logic [3:0] DEST_TO_MIDDLE_LAYER_ERROR = 4'd7;
    localparam logic [3:0] DEST_LAST_VALID            = DEST_TO_MIDDLE_LAYER_ERROR;
    localparam logic [3:0] DEST_NONE                  = 4'd15;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_ACC  = 3'd2,
        ST_BIAS = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

    // One cycle's worth of ALU_cells control
    typedef struct packed {
        logic [4:0] mux_1;
        logic [4:0] mux_2;
        logic [1:0] mux_3;
        logic [3:0] mux_4;
        logic       enable;
        logic [1:0] op;
        logic [3:0] demux;
        logic       wr_en;
        logic [4:0] wr_addr;
    } ctrl_word_t;

    // Control word while nothing is being computed (also the reset value)
    localparam ctrl_word_t CTRL_IDLE = '{
        mux_1   : 5'd0,
        mux_2   : 5'd0,
        mux_3   : MUX3_PIXEL,
        mux_4   : MUX4_IDLE,
        enable  : 1'b0,
        op      : OP_ADD,
        demux   : DEST_NONE,
        wr_en   : 1'b0,
        wr_addr : 5'd0
    };

    // Destinations without a physical demux output collapse to "none"
    function automatic logic [3:0] normalize_dest(input logic [3:0] dest);
        return (dest > DEST_LAST_VALID) ? DEST_NONE : dest;
    endfunction

    // Bank 2 word address for a term index
    function automatic logic [4:0] bank2_addr(input logic [3:0] idx);
        return BANK2_BASE + {1'b0, idx};
    endfunction

endpackage : ae_ctrl_pkg
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_decode
//  Description : Combinational decode of sequencer state, term index and
//                latched command into the ALU_cells control word.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import ae_ctrl_pkg::*;
(
    input  seq_state_t i_state,
    input  logic [3:0] i_idx,
    input  logic       i_bias_sel,
    input  logic [3:0] i_dest,
    output ctrl_word_t o_ctrl
);

    // Map each state to its operand selects, op and write-back target
    always_comb begin
        o_ctrl = CTRL_IDLE;
        case (i_state)
            ST_MUL: begin
                // bank1[i] * bank2[i], product overwrites bank2[i]
                o_ctrl.mux_1   = {1'b0, i_idx};
                o_ctrl.mux_2   = bank2_addr(i_idx);
                o_ctrl.mux_3   = MUX3_MUX1;
                o_ctrl.mux_4   = MUX4_MUX2;
                o_ctrl.op      = OP_MUL;
                o_ctrl.enable  = 1'b1;
                o_ctrl.wr_en   = 1'b1;
                o_ctrl.wr_addr = bank2_addr(i_idx);
            end
            ST_ACC: begin
                // Running sum lives in bank2[0]; fold in product k
                o_ctrl.mux_1   = BANK2_BASE;
                o_ctrl.mux_2   = bank2_addr(i_idx);
                o_ctrl.mux_3   = MUX3_MUX1;
                o_ctrl.mux_4   = MUX4_MUX2;
                o_ctrl.op      = OP_ADD;
                o_ctrl.enable  = 1'b1;
                o_ctrl.wr_en   = 1'b1;
                o_ctrl.wr_addr = BANK2_BASE;
            end
            ST_BIAS: begin
                // Sum plus bias, steered out; nothing written back
                o_ctrl.mux_1   = BANK2_BASE;
                o_ctrl.mux_3   = MUX3_MUX1;
                o_ctrl.mux_4   = i_bias_sel ? MUX4_OUTPUT_BIAS : MUX4_INPUT_BIAS;
                o_ctrl.op      = OP_ADD;
                o_ctrl.enable  = 1'b1;
                o_ctrl.demux   = i_dest;
            end
            default: o_ctrl = CTRL_IDLE;
        endcase
    end

endmodule : alu_ctrl_decode
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Sequences ALU_cells through one neuron evaluation:
//                len element-wise products, their summation and a bias add,
//                with a start/done handshake towards the top-level FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import ae_ctrl_pkg::*;
#(
    parameter int N_MAX = 9
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] cmd_len,
    input  logic       cmd_bias_sel,
    input  logic [3:0] cmd_dest,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [4:0] mux_1_control,
    output logic [4:0] mux_2_control,
    output logic [1:0] mux_3_control,
    output logic [3:0] mux_4_control,
    output logic       enable_ALU,
    output logic [1:0] op_select,
    output logic [3:0] demux_1_control,
    output logic       mem_wr_en,
    output logic [4:0] mem_wr_addr
);

    localparam logic [3:0] c_len_max = 4'(N_MAX);

    seq_state_t r_state;
    logic [3:0] r_idx;
    logic [3:0] r_len;
    logic       r_bias_sel;
    logic [3:0] r_dest;
    ctrl_word_t r_ctrl;
    logic       r_busy;
    logic       r_done;
    logic       r_err;

    seq_state_t w_next_state;
    logic [3:0] w_next_idx;
    logic       w_accept;
    logic       w_reject;
    logic       w_len_legal;
    logic       w_last;
    logic       w_next_bias_sel;
    logic [3:0] w_next_dest;
    ctrl_word_t w_next_ctrl;

    assign w_len_legal = (cmd_len != 4'd0) && (cmd_len <= c_len_max);
    assign w_last      = (r_idx == (r_len - 4'd1));

    // Next state / index; controls are decoded from the next state so that
    // they land in the same cycle as the state they describe
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_len_legal) begin
                        w_accept     = 1'b1;
                        w_next_state = ST_MUL;
                        w_next_idx   = 4'd0;
                    end else begin
                        w_reject     = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (!w_last) begin
                    w_next_idx = r_idx + 4'd1;
                end else if (r_len > 4'd1) begin
                    w_next_state = ST_ACC;
                    w_next_idx   = 4'd1;
                end else begin
                    w_next_state = ST_BIAS;
                end
            end
            ST_ACC: begin
                if (w_last) begin
                    w_next_state = ST_BIAS;
                end else begin
                    w_next_idx = r_idx + 4'd1;
                end
            end
            ST_BIAS: w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_next_bias_sel = w_accept ? cmd_bias_sel : r_bias_sel;
    assign w_next_dest     = w_accept ? normalize_dest(cmd_dest) : r_dest;

    alu_ctrl_decode u_decode (
        .i_state    (w_next_state),
        .i_idx      (w_next_idx),
        .i_bias_sel (w_next_bias_sel),
        .i_dest     (w_next_dest),
        .o_ctrl     (w_next_ctrl)
    );

    // State, latched command and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= 4'd0;
            r_len      <= 4'd0;
            r_bias_sel <= 1'b0;
            r_dest     <= DEST_NONE;
            r_ctrl     <= CTRL_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            if (w_accept) begin
                r_len <= cmd_len;
            end
            r_bias_sel <= w_next_bias_sel;
            r_dest     <= w_next_dest;
            r_ctrl     <= w_next_ctrl;
            r_busy     <= (w_next_state != ST_IDLE);
            r_done     <= (w_next_state == ST_DONE);
            r_err      <= w_reject;
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign err             = r_err;
    assign mux_1_control   = r_ctrl.mux_1;
    assign mux_2_control   = r_ctrl.mux_2;
    assign mux_3_control   = r_ctrl.mux_3;
    assign mux_4_control   = r_ctrl.mux_4;
    assign enable_ALU      = r_ctrl.enable;
    assign op_select       = r_ctrl.op;
    assign demux_1_control = r_ctrl.demux;
    assign mem_wr_en       = r_ctrl.wr_en;
    assign mem_wr_addr     = r_ctrl.wr_addr;

endmodule : alu_sequencer
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer. A small behavioural
//                ALU_cells/bank model follows the DUT controls; expected
//                results come from a reference sum-of-products per command.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
    import ae_ctrl_pkg::*;

    localparam int INPUT_BIAS  = 10;
    localparam int OUTPUT_BIAS = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] cmd_len;
    logic       cmd_bias_sel;
    logic [3:0] cmd_dest;
    logic       busy, done, err;
    logic [4:0] mux_1_control, mux_2_control;
    logic [1:0] mux_3_control;
    logic [3:0] mux_4_control;
    logic       enable_ALU;
    logic [1:0] op_select;
    logic [3:0] demux_1_control;
    logic       mem_wr_en;
    logic [4:0] mem_wr_addr;

    always #5 clk = ~clk;

    alu_sequencer #(.N_MAX(9)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cmd_len         (cmd_len),
        .cmd_bias_sel    (cmd_bias_sel),
        .cmd_dest        (cmd_dest),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .mux_1_control   (mux_1_control),
        .mux_2_control   (mux_2_control),
        .mux_3_control   (mux_3_control),
        .mux_4_control   (mux_4_control),
        .enable_ALU      (enable_ALU),
        .op_select       (op_select),
        .demux_1_control (demux_1_control),
        .mem_wr_en       (mem_wr_en),
        .mem_wr_addr     (mem_wr_addr)
    );

    typedef struct {
        int len;
        int bias_sel;
        int dest;
        int pat;      // bank contents: 0 -> both 1..9, 1 -> bank1 3.., bank2 4..
        int repulse;  // cycle at which a stray start is pulsed (0 = none)
    } vec_t;

    typedef struct {
        bit is_err;
        int latency;
        int value;
        int dest;
        int writes;
        bit acc;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   bank1[9];
    int   bank2[9];
    bit   pend_wr;
    int   pend_addr, pend_val;
    int   wr_cnt, route_cnt, route_dest, route_val;
    bit   acc_seen, busy_ever, en_ever;
    exp_t sb[$];
    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int bank_word(input int a);
        if (a < 9)  return bank1[a];
        if (a < 18) return bank2[a-9];
        return 0;
    endfunction

    // Behavioural ALU_cells datapath driven by the current control outputs
    function automatic int alu_out();
        int a, b;
        a = (mux_3_control == 2'd1) ? bank_word(int'(mux_1_control)) : 0;
        case (mux_4_control)
            4'd7:    b = bank_word(int'(mux_2_control));
            4'd1:    b = INPUT_BIAS;
            4'd2:    b = OUTPUT_BIAS;
            default: b = 0;
        endcase
        case (op_select)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a * b;
            default: return -1;
        endcase
    endfunction

    function automatic int pat_b1(input int pat, input int i);
        return (pat == 0) ? i + 1 : i + 3;
    endfunction

    function automatic int pat_b2(input int pat, input int i);
        return (pat == 0) ? i + 1 : i + 4;
    endfunction

    task automatic reload(input int pat);
        for (int i = 0; i < 9; i++) begin
            bank1[i] = pat_b1(pat, i);
            bank2[i] = pat_b2(pat, i);
        end
        pend_wr = 1'b0;
    endtask

    function automatic exp_t predict(input vec_t v);
        exp_t e;
        int   s;
        e.is_err = (v.len < 1) || (v.len > 9);
        if (e.is_err) begin
            e.latency = 1; e.value = 0; e.dest = 15; e.writes = 0; e.acc = 1'b0;
        end else begin
            s = 0;
            for (int i = 0; i < v.len; i++) s += pat_b1(v.pat, i) * pat_b2(v.pat, i);
            e.value   = s + ((v.bias_sel != 0) ? OUTPUT_BIAS : INPUT_BIAS);
            e.dest    = (v.dest <= 7) ? v.dest : 15;
            e.latency = 2 * v.len + 1;
            e.writes  = 2 * v.len - 1;
            e.acc     = (v.len > 1);
        end
        return e;
    endfunction

    // Observe one cycle of DUT controls (called mid-cycle, on the falling edge)
    task automatic sample();
        int r;
        r = alu_out();
        pend_wr = mem_wr_en;
        if (mem_wr_en) begin
            pend_addr = int'(mem_wr_addr);
            pend_val  = r;
            wr_cnt++;
        end
        if (enable_ALU && demux_1_control != 4'd15) begin
            route_cnt++;
            route_dest = int'(demux_1_control);
            route_val  = r;
        end
        if (enable_ALU && op_select == 2'b00 && mux_1_control == 5'd9 && mux_4_control == 4'd7)
            acc_seen = 1'b1;
        busy_ever = busy_ever | busy;
        en_ever   = en_ever | enable_ALU;
    endtask

    // Bank write happens at the rising edge
    task automatic apply_write();
        if (pend_wr) begin
            if (pend_addr < 9)       bank1[pend_addr] = pend_val;
            else if (pend_addr < 18) bank2[pend_addr-9] = pend_val;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_done"},  int'(done), 0);
        check({tag, "_err"},   int'(err), 0);
        check({tag, "_mux1"},  int'(mux_1_control), 0);
        check({tag, "_mux2"},  int'(mux_2_control), 0);
        check({tag, "_mux3"},  int'(mux_3_control), 0);
        check({tag, "_mux4"},  int'(mux_4_control), 0);
        check({tag, "_en"},    int'(enable_ALU), 0);
        check({tag, "_op"},    int'(op_select), 0);
        check({tag, "_demux"}, int'(demux_1_control), 15);
        check({tag, "_wren"},  int'(mem_wr_en), 0);
        check({tag, "_wradr"}, int'(mem_wr_addr), 0);
    endtask

    // Issue one command (called on a falling edge), then score the outcome
    task automatic run_cmd(input vec_t v);
        exp_t e;
        int   lat;
        bit   seen, err_seen;
        reload(v.pat);
        wr_cnt = 0; route_cnt = 0; route_dest = 15; route_val = 0;
        acc_seen = 1'b0; busy_ever = 1'b0; en_ever = 1'b0;
        sb.push_back(predict(v));
        start        = 1'b1;
        cmd_len      = v.len[3:0];
        cmd_bias_sel = v.bias_sel[0];
        cmd_dest     = v.dest[3:0];
        @(posedge clk);
        lat = 0; seen = 1'b0; err_seen = 1'b0;
        for (int c = 1; c <= 45 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (v.repulse != 0 && c == v.repulse) begin
                start = 1'b1; cmd_len = 4'd2; cmd_bias_sel = ~cmd_bias_sel; cmd_dest = 4'd5;
            end else if (v.repulse != 0 && c == v.repulse + 1) begin
                start = 1'b0;
            end
            sample();
            if (done || err) begin
                seen = 1'b1; lat = c; err_seen = err;
            end else begin
                @(posedge clk);
                apply_write();
            end
        end
        e = sb.pop_front();
        check("latency", lat, e.latency);
        check("err_flag", int'(err_seen), int'(e.is_err));
        if (e.is_err) begin
            check("busy_on_reject", int'(busy_ever), 0);
            check("enable_on_reject", int'(en_ever), 0);
        end else begin
            check("route_count", route_cnt, (e.dest == 15) ? 0 : 1);
            check("result_dest", route_dest, e.dest);
            if (e.dest != 15) check("result_value", route_val, e.value);
            check("write_strobes", wr_cnt, e.writes);
            check("acc_visited", int'(acc_seen), int'(e.acc));
            check("busy_at_done", int'(busy), 1);
        end
        @(posedge clk);
        @(negedge clk);
        check("done_pulse_end", int'(done), 0);
        check("err_pulse_end", int'(err), 0);
        check("busy_after", int'(busy), 0);
        check("enable_after", int'(enable_ALU), 0);
        check("demux_after", int'(demux_1_control), 15);
    endtask

    initial begin
        vecs[0] = '{9, 0, 0,  0, 0};   // full length, input bias -> 295
        vecs[1] = '{1, 1, 3,  1, 0};   // single term, output bias -> 17
        vecs[2] = '{3, 1, 7,  1, 0};   // last valid destination
        vecs[3] = '{2, 0, 10, 0, 0};   // unmapped destination -> none
        vecs[4] = '{0, 0, 1,  0, 0};   // rejected: zero length
        vecs[5] = '{12, 0, 2, 0, 0};   // rejected: too long
        vecs[6] = '{9, 0, 0,  0, 12};  // stray start during ACC(3)
        vecs[7] = '{9, 1, 6,  1, 0};

        rst = 1'b1; start = 1'b0; cmd_len = 4'd0; cmd_bias_sel = 1'b0; cmd_dest = 4'd0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

        // Reset while in MUL(4): outputs drop at once, command abandoned
        reload(0);
        start = 1'b1; cmd_len = 4'd9; cmd_bias_sel = 1'b0; cmd_dest = 4'd0;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c < 5) @(posedge clk);
        end
        check("mul4_mux1", int'(mux_1_control), 4);
        check("mul4_wraddr", int'(mem_wr_addr), 13);
        #1 rst = 1'b1;
        #1 check_reset("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_cmd(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_sequencer
`default_nettype wire
